fwrisc_callstack_checker: RTL

// - Downstream consumer of the callstack cache's expected-link output (exp_data/exp_data_valid).
// - Keeps a shadow return-address stack:
//   - push on every exp_data_valid;
//   - pop and compare on every load that writes a link register (x1/x5).
// - Flags callstack stomping: a restored link value that differs from the one saved at call time.
// - Sits beside the core's writeback path. Observation only; it never stalls the core.
//

---
 rtl/fwrisc_callstack_checker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fwrisc_callstack_checker.sv
// fwrisc_callstack_checker
//   Shadow return-address stack beside the writeback path. The callstack cache
//   pushes an expected link value (exp_data/exp_data_valid). A load that writes
//   x1 or x5 pops the stack and checks the restored value. A restored link that
//   differs from the saved one is reported one cycle later on err_valid.
//   The checker only observes the core and never stalls it.
//   Optional build macro: FWRISC_CALLSTACK_CHECKER_WRAP_EN. When it is defined,
//   a push onto a full stack overwrites the oldest entry. Otherwise that push is
//   dropped.
module fwrisc_callstack_checker #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              exp_data,
    input  logic                     exp_data_valid,
    input  logic                     ld_valid,
    input  logic [5:0]               ld_rd,
    input  logic [31:0]              ld_data,
    output logic                     err_valid,
    output logic [31:0]              err_exp,
    output logic [31:0]              err_act,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow,
    output logic                     underflow,
    output logic [15:0]              mismatch_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ONE_D = 1;
    localparam logic [PW-1:0] ONE_P = 1;

    logic [31:0]   stack_mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] top_idx;
    logic [PW-1:0] wr_idx;
    logic [PW:0]   depth_nxt;
    logic [31:0]   top_data;
    logic          pop;
    logic          empty;
    logic          full;
    logic          do_cmp;
    logic          mis;
    logic          do_write;
    logic          uf_set;
    logic          of_set;

    assign top_data = stack_mem[top_idx];

    // Decode pop/push and work out the next pointer, occupancy and write slot
    always_comb begin
        pop       = ld_valid && (ld_rd == 6'd1 || ld_rd == 6'd5);
        empty     = (depth == '0);
        full      = (depth == FULL);
        top_idx   = ptr - ONE_P;
        do_cmp    = pop && !empty;
        mis       = do_cmp && (ld_data != top_data);
        ptr_nxt   = ptr;
        depth_nxt = depth;
        wr_idx    = ptr;
        do_write  = 1'b0;
        uf_set    = pop && empty;
        of_set    = 1'b0;
        if (exp_data_valid) begin
            if (do_cmp) begin
                // Pop frees the top slot and the push refills it in place.
                // Pointer and occupancy stay put, so a full stack cannot overflow here.
                wr_idx   = top_idx;
                do_write = 1'b1;
            end else if (!full) begin
                do_write  = 1'b1;
                ptr_nxt   = ptr + ONE_P;
                depth_nxt = depth + ONE_D;
            end else begin
                of_set = 1'b1;
`ifdef FWRISC_CALLSTACK_CHECKER_WRAP_EN
                // When full, ptr points at the oldest entry, so this write replaces it.
                do_write = 1'b1;
                ptr_nxt  = ptr + ONE_P;
`endif
            end
        end else if (do_cmp) begin
            ptr_nxt   = top_idx;
            depth_nxt = depth - ONE_D;
        end
    end

    // Stack storage; entries are not reset
    always_ff @(posedge clock) begin
        if (reset && do_write) begin
            stack_mem[wr_idx] <= exp_data;
        end
    end

    // Pointer, occupancy, sticky flags and error reporting
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr          <= '0;
            depth        <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            err_valid    <= 1'b0;
            err_exp      <= '0;
            err_act      <= '0;
            mismatch_cnt <= '0;
        end else begin
            ptr       <= ptr_nxt;
            depth     <= depth_nxt;
            err_valid <= mis;
            if (of_set) overflow  <= 1'b1;
            if (uf_set) underflow <= 1'b1;
            if (mis) begin
                err_exp <= top_data;
                err_act <= ld_data;
                if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
            end
        end
    end

endmodule
